// File: rtl/vga_pkg.sv
// Shared SVGA 800x600@60 timing constants and counter type, used by the timing
// generator and by the drawing stages downstream of it.
package vga_pkg;

   localparam int unsigned CNT_W = 11;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam int unsigned SVGA_H_ACTIVE = 800;
   localparam int unsigned SVGA_H_FP     = 40;
   localparam int unsigned SVGA_H_SYNC   = 128;
   localparam int unsigned SVGA_H_BP     = 88;
   localparam int unsigned SVGA_H_TOTAL  = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;

   localparam int unsigned SVGA_V_ACTIVE = 600;
   localparam int unsigned SVGA_V_FP     = 1;
   localparam int unsigned SVGA_V_SYNC   = 4;
   localparam int unsigned SVGA_V_BP     = 23;
   localparam int unsigned SVGA_V_TOTAL  = SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running pixel/line counters with sync and
// blanking flags decoded from the next-count values so they align with the counts.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
   parameter int unsigned H_FP     = SVGA_H_FP,
   parameter int unsigned H_SYNC   = SVGA_H_SYNC,
   parameter int unsigned H_BP     = SVGA_H_BP,
   parameter int unsigned V_ACTIVE = SVGA_V_ACTIVE,
   parameter int unsigned V_FP     = SVGA_V_FP,
   parameter int unsigned V_SYNC   = SVGA_V_SYNC,
   parameter int unsigned V_BP     = SVGA_V_BP,
   parameter bit          SYNC_POL = 1'b1
) (
   input  logic             pclk,
   input  logic             rst,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             hblnk,
   output logic             vsync,
   output logic             vblnk,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
      $error("vga_timing: H_TOTAL/V_TOTAL must not exceed 2047 for 11-bit counters");
   end

   localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
   localparam cnt_t H_BLK     = cnt_t'(H_ACTIVE);
   localparam cnt_t H_SYNC_LO = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t H_SYNC_HI = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t V_BLK     = cnt_t'(V_ACTIVE);
   localparam cnt_t V_SYNC_LO = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t V_SYNC_HI = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

   cnt_t hcount_q, hcount_d;
   cnt_t vcount_q, vcount_d;
   logic hsync_q, hsync_d;
   logic hblnk_q, hblnk_d;
   logic vsync_q, vsync_d;
   logic vblnk_q, vblnk_d;
   logic fstart_q, fstart_d;
   logic h_wrap;

   always_comb begin
      h_wrap   = (hcount_q == H_LAST);
      hcount_d = h_wrap ? '0 : hcount_q + cnt_t'(1);
      vcount_d = vcount_q;
      if (h_wrap) begin
         vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + cnt_t'(1);
      end
      // Flags follow the counts being loaded this edge, giving zero relative latency.
      hblnk_d  = (hcount_d >= H_BLK);
      hsync_d  = ((hcount_d >= H_SYNC_LO) && (hcount_d < H_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
      vblnk_d  = (vcount_d >= V_BLK);
      vsync_d  = ((vcount_d >= V_SYNC_LO) && (vcount_d < V_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
      fstart_d = (hcount_d == '0) && (vcount_d == '0);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         hcount_q <= '0;
         vcount_q <= '0;
         hsync_q  <= ~SYNC_POL;
         hblnk_q  <= 1'b0;
         vsync_q  <= ~SYNC_POL;
         vblnk_q  <= 1'b0;
         fstart_q <= 1'b0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         hsync_q  <= hsync_d;
         hblnk_q  <= hblnk_d;
         vsync_q  <= vsync_d;
         vblnk_q  <= vblnk_d;
         fstart_q <= fstart_d;
      end
   end

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hsync       = hsync_q;
   assign hblnk       = hblnk_q;
   assign vsync       = vsync_q;
   assign vblnk       = vblnk_q;
   assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (SVGA defaults, small raster with active-high
// and active-low syncs) compared every cycle against a cycle-count raster model.
module tb_vga_timing;

   logic pclk = 1'b0;
   logic rst  = 1'b1;
   always #5 pclk = ~pclk;

   // Small raster: 28 pixels x 17 lines, 476 cycles per frame.
   localparam int SH_A = 16, SH_F = 3, SH_S = 5, SH_B = 4;
   localparam int SV_A = 10, SV_F = 2, SV_S = 3, SV_B = 2;

   logic [10:0] d_h, d_v, s_h, s_v, n_h, n_v;
   logic d_hs, d_hb, d_vs, d_vb, d_fs;
   logic s_hs, s_hb, s_vs, s_vb, s_fs;
   logic n_hs, n_hb, n_vs, n_vb, n_fs;

   vga_timing u_def (
      .pclk(pclk), .rst(rst), .hcount(d_h), .vcount(d_v), .hsync(d_hs),
      .hblnk(d_hb), .vsync(d_vs), .vblnk(d_vb), .frame_start(d_fs));

   vga_timing #(.H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
                .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b1)) u_sp (
      .pclk(pclk), .rst(rst), .hcount(s_h), .vcount(s_v), .hsync(s_hs),
      .hblnk(s_hb), .vsync(s_vs), .vblnk(s_vb), .frame_start(s_fs));

   vga_timing #(.H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
                .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b0)) u_sn (
      .pclk(pclk), .rst(rst), .hcount(n_h), .vcount(n_v), .hsync(n_hs),
      .hblnk(n_hb), .vsync(n_vs), .vblnk(n_vb), .frame_start(n_fs));

   typedef struct packed {
      int h;
      int v;
      bit hs;
      bit hb;
      bit vs;
      bit vb;
      bit fs;
   } exp_t;

   int tests = 0;
   int fails = 0;
   int ncyc  = 0;
   int s_fcnt, s_hmax, s_vmax, d_hmax, d_vmax;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d after reset)", tag, got, exp, ncyc);
      end
   endtask

   // Raster position is just the number of pixel clocks since reset, folded by the totals.
   function automatic exp_t model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                  input bit pol, input int cyc);
      exp_t e;
      int ht, vt;
      ht   = ha + hf + hs + hb;
      vt   = va + vf + vs + vb;
      e.h  = cyc % ht;
      e.v  = (cyc / ht) % vt;
      e.hb = (e.h >= ha);
      e.vb = (e.v >= va);
      e.hs = ((e.h >= ha + hf) && (e.h < ha + hf + hs)) ? pol : !pol;
      e.vs = ((e.v >= va + vf) && (e.v < va + vf + vs)) ? pol : !pol;
      e.fs = (cyc > 0) && (cyc % (ht * vt) == 0);
      return e;
   endfunction

   task automatic check_inst(input string p, input logic [10:0] h, v,
                             input logic hs, hb, vs, vb, fs, input exp_t e);
      chk({p, ".hcount"}, 32'(h), e.h);
      chk({p, ".vcount"}, 32'(v), e.v);
      chk({p, ".hsync"}, 32'(hs), 32'(e.hs));
      chk({p, ".hblnk"}, 32'(hb), 32'(e.hb));
      chk({p, ".vsync"}, 32'(vs), 32'(e.vs));
      chk({p, ".vblnk"}, 32'(vb), 32'(e.vb));
      chk({p, ".frame_start"}, 32'(fs), 32'(e.fs));
   endtask

   task automatic tick(input bit r);
      rst = r;
      @(posedge pclk);
      ncyc = r ? 0 : ncyc + 1;
      @(negedge pclk);
      check_inst("def", d_h, d_v, d_hs, d_hb, d_vs, d_vb, d_fs,
                 model(800, 40, 128, 88, 600, 1, 4, 23, 1'b1, ncyc));
      check_inst("pos", s_h, s_v, s_hs, s_hb, s_vs, s_vb, s_fs,
                 model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, ncyc));
      check_inst("neg", n_h, n_v, n_hs, n_hb, n_vs, n_vb, n_fs,
                 model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b0, ncyc));
      if (s_fs === 1'b1) s_fcnt++;
      if (int'(s_h) > s_hmax) s_hmax = int'(s_h);
      if (int'(s_v) > s_vmax) s_vmax = int'(s_v);
      if (int'(d_h) > d_hmax) d_hmax = int'(d_h);
      if (int'(d_v) > d_vmax) d_vmax = int'(d_v);
   endtask

   initial begin
      repeat (3) tick(1'b1);

      // Free run from reset: more than two small frames and the whole first SVGA line.
      s_fcnt = 0; s_hmax = 0; s_vmax = 0; d_hmax = 0; d_vmax = 0;
      repeat (1200) tick(1'b0);
      chk("pos.frame_count", s_fcnt, 1200 / ((SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B)));
      chk("pos.hcount_max", s_hmax, SH_A + SH_F + SH_S + SH_B - 1);
      chk("pos.vcount_max", s_vmax, SV_A + SV_F + SV_S + SV_B - 1);
      chk("def.hcount_max", d_hmax, 1055);
      chk("def.vcount_max", d_vmax, 1);

      // Random run lengths interleaved with random-length resets.
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(1, 600)) tick(1'b0);
         repeat ($urandom_range(1, 3)) tick(1'b1);
      end

      // One-cycle reset while the small raster is inside both hsync and vsync.
      repeat (13 * 28 + 20) tick(1'b0);
      chk("pos.in_hsync_before_rst", 32'(s_hs), 32'd1);
      chk("pos.in_vsync_before_rst", 32'(s_vs), 32'd1);
      tick(1'b1);
      chk("pos.rst_hcount", 32'(s_h), 32'd0);
      chk("pos.rst_vcount", 32'(s_v), 32'd0);
      chk("neg.rst_hsync_idle", 32'(n_hs), 32'd1);
      chk("neg.rst_vsync_idle", 32'(n_vs), 32'd1);
      tick(1'b0);
      chk("def.first_hcount", 32'(d_h), 32'd1);
      chk("def.first_vcount", 32'(d_v), 32'd0);
      repeat (600) tick(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 40: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 128: hsync width, in pixels.
REQ-004 SHALL have parameter H_BP, default 88: horizontal back porch; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1056.
REQ-005 SHALL have parameter V_ACTIVE, default 600: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 1: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 4: vsync width, in lines.
REQ-008 SHALL have parameter V_BP, default 23: vertical back porch; V_TOTAL = 628.
REQ-009 SHALL have parameter SYNC_POL, default 1: active level of hsync and vsync.
REQ-010 SHALL have port pclk  input  1  pixel clock (40 MHz for defaults); the only clock.
REQ-011 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-012 SHALL have port hcount  output  11  current pixel column, 0..H_TOTAL-1.
REQ-013 SHALL have port vcount  output  11  current line, 0..V_TOTAL-1.
REQ-014 SHALL have port hsync  output  1  horizontal sync.
REQ-015 SHALL have port hblnk  output  1  horizontal blanking.
REQ-016 SHALL have port vsync  output  1  vertical sync.
REQ-017 SHALL have port vblnk  output  1  vertical blanking.
REQ-018 SHALL have port frame_start  output  1  one-cycle pulse at pixel (0,0).

Function
REQ-019 SHALL drive all outputs from registers, with no combinational path from input to output.
REQ-020 SHALL increment hcount by 1 on every pclk edge while rst is low.
REQ-021 SHALL wrap hcount from H_TOTAL-1 (1055) to 0 and, in the same edge, increment vcount.
REQ-022 SHALL wrap vcount from V_TOTAL-1 (627) to 0 when hcount wraps on the last line.
REQ-023 SHALL keep vcount unchanged on every edge where hcount does not wrap.
REQ-024 SHALL decode hblnk, hsync, vblnk, vsync and frame_start from the next-count values, so each flag is coherent with the hcount/vcount presented in the same cycle (zero relative latency).
REQ-025 SHALL assert hblnk exactly when hcount >= H_ACTIVE, i.e. 800..1055.
REQ-026 SHALL drive hsync = SYNC_POL exactly when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967, and drive it to the inactive level otherwise.
REQ-027 SHALL assert vblnk exactly when vcount >= V_ACTIVE, i.e. 600..627, for every hcount of those lines.
REQ-028 SHALL drive vsync = SYNC_POL exactly when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 601..604, and drive it to the inactive level otherwise.
REQ-029 SHALL assert frame_start for one cycle when (hcount,vcount) becomes (0,0) through a wrap; it SHALL NOT be asserted by reset.
REQ-030 SHALL keep the last visible pixel (799,599) unblanked, so downstream border logic sees hcount 0..799 and vcount 0..599.
REQ-031 SHALL keep counter arithmetic 11-bit unsigned; parameter totals above 2047 are illegal and SHALL be rejected by an elaboration-time check.

Reset
REQ-032 SHALL, on any pclk edge with rst high, load hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0, and hsync=vsync=!SYNC_POL.
REQ-033 SHALL honour rst asserted mid-frame or mid-sync in the next edge, with no partial line completion.
REQ-034 SHALL produce hcount=1, vcount=0 on the first edge after rst deasserts.

Structure
REQ-035 SHALL place the SVGA 800x600@60 timing constants (all eight H/V values and the totals) in shared package vga_pkg, also used by the drawing stages.
REQ-036 SHALL be implemented as one flat module; a separate counter sub-module is not warranted.

Verification
REQ-037 SHALL cover: release rst, run 1056*628 cycles -> exactly one frame_start, at the wrap (1055,627)->(0,0); hcount max 1055, vcount max 627.
REQ-038 SHALL cover: line 0 scan -> hblnk rises at hcount=800, hsync active for hcount 840..967 (128 cycles), hblnk falls at hcount=0.
REQ-039 SHALL cover: full frame -> vblnk high for vcount 600..627; vsync active for vcount 601..604 (4*1056 cycles).
REQ-040 SHALL cover: rst pulsed for 1 cycle at (900,602) -> next cycle outputs are (0,0), syncs inactive, blanks 0, frame_start 0.
REQ-041 SHALL cover: SYNC_POL=0 -> hsync low for 840..967 only, vsync low for 601..604 only, idle high after reset.
REQ-042 SHALL cover: a check on every cycle that hblnk==(hcount>=800) and vblnk==(vcount>=600).
